// File: rtl/systolic_conv_seq.sv
// Sequencer for a weight-stationary systolic array: loads K weight rows,
// streams skewed input vectors into the active rows, raises skewed
// output-collect enables on the active columns, then pulses done.
module systolic_conv_seq #(
    parameter int ROWS  = 32,
    parameter int COLS  = 32,
    parameter int CNT_W = 8,
    localparam int RW   = $clog2(ROWS + 1),
    localparam int CW   = $clog2(COLS + 1),
    localparam int TW   = CNT_W + $clog2(ROWS + COLS) + 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [RW-1:0]    k_rows,
    input  logic [CW-1:0]    act_cols,
    input  logic [CNT_W-1:0] stream_len,
    input  logic             stall,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             w_ps,
    output logic [ROWS-1:0]  w_load_en,
    output logic [ROWS-1:0]  input_en,
    output logic [COLS-1:0]  out_en
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [RW-1:0]    r_q, r_d;
    logic [TW-1:0]    t_q, t_d;
    logic [RW-1:0]    k_q, k_d;
    logic [CW-1:0]    a_q, a_d;
    logic [CNT_W-1:0] s_q, s_d;

    // Job geometry widened to the timer width so the bounds never wrap.
    logic [TW-1:0] k_w, a_w, s_w;
    logic [TW-1:0] stream_last, drain_last;
    logic          cfg_ok;
    logic          r_last;

    assign k_w         = TW'(k_q);
    assign a_w         = TW'(a_q);
    assign s_w         = TW'(s_q);
    assign stream_last = k_w + s_w - TW'(2);
    assign drain_last  = k_w + a_w + s_w - TW'(2);
    assign r_last      = (r_q == k_q - RW'(1));

    assign cfg_ok = (k_rows != '0) && (k_rows <= RW'(ROWS)) &&
                    (act_cols != '0) && (act_cols <= CW'(COLS)) &&
                    (stream_len != '0);

    // Next-state: job acceptance, row/timer advance, stall hold, abort.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        t_d     = t_q;
        k_d     = k_q;
        a_d     = a_q;
        s_d     = s_q;
        case (state_q)
            IDLE: begin
                if (start && cfg_ok) begin
                    k_d     = k_rows;
                    a_d     = act_cols;
                    s_d     = stream_len;
                    r_d     = '0;
                    t_d     = '0;
                    state_d = LOAD_W;
                end
            end
            LOAD_W: begin
                if (!stall) begin
                    if (r_last) begin
                        r_d     = '0;
                        t_d     = '0;
                        state_d = STREAM;
                    end else begin
                        r_d = r_q + RW'(1);
                    end
                end
            end
            STREAM: begin
                if (!stall) begin
                    t_d = t_q + TW'(1);
                    if (t_q == stream_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!stall) begin
                    if (t_q == drain_last) begin
                        t_d     = '0;
                        state_d = DONE;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort wins over stall and everything else once a job is running.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            r_d     = '0;
            t_d     = '0;
        end
    end

    // Control state and counters.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            r_q     <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            t_q     <= t_d;
        end
    end

    // Latched job configuration; only meaningful while a job is active.
    always_ff @(posedge clk) begin
        k_q <= k_d;
        a_q <= a_d;
        s_q <= s_d;
    end

    // Output decode from registered state; stall gates the enables directly.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        w_ps      = 1'b1;
        w_load_en = '0;
        input_en  = '0;
        out_en    = '0;
        case (state_q)
            LOAD_W: begin
                busy = 1'b1;
                if (!stall) begin
                    w_load_en = ROWS'(1) << r_q;
                end
            end
            STREAM, DRAIN: begin
                busy = 1'b1;
                w_ps = 1'b0;
                for (int i = 0; i < ROWS; i++) begin
                    input_en[i] = !stall && (TW'(i) < k_w) &&
                                  (t_q >= TW'(i)) && (t_q < TW'(i) + s_w);
                end
                for (int c = 0; c < COLS; c++) begin
                    out_en[c] = !stall && (TW'(c) < a_w) &&
                                (t_q >= k_w + TW'(c)) &&
                                (t_q < k_w + TW'(c) + s_w);
                end
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_systolic_conv_seq.sv
// Bench for systolic_conv_seq: a 4x4 instance driven from a per-cycle
// vector table, and a full-size instance for the long job and async reset.
module tb_systolic_conv_seq;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    // Small 4x4 instance signals
    logic       start, stall, abort;
    logic [2:0] k_rows, act_cols;
    logic [7:0] stream_len;
    logic       busy, done, w_ps;
    logic [3:0] w_load_en, input_en, out_en;

    // Full-size instance signals
    logic        start_b, stall_b, abort_b;
    logic [5:0]  k_b, a_b;
    logic [7:0]  s_b;
    logic        busy_b, done_b, w_ps_b;
    logic [31:0] w_load_en_b, input_en_b, out_en_b;

    systolic_conv_seq #(.ROWS(4), .COLS(4), .CNT_W(8)) dut (
        .clk(clk), .nrst(nrst), .start(start), .k_rows(k_rows),
        .act_cols(act_cols), .stream_len(stream_len), .stall(stall),
        .abort(abort), .busy(busy), .done(done), .w_ps(w_ps),
        .w_load_en(w_load_en), .input_en(input_en), .out_en(out_en)
    );

    systolic_conv_seq dut_b (
        .clk(clk), .nrst(nrst), .start(start_b), .k_rows(k_b),
        .act_cols(a_b), .stream_len(s_b), .stall(stall_b),
        .abort(abort_b), .busy(busy_b), .done(done_b), .w_ps(w_ps_b),
        .w_load_en(w_load_en_b), .input_en(input_en_b), .out_en(out_en_b)
    );

    typedef struct {
        logic        st;
        logic [2:0]  k;
        logic [2:0]  a;
        logic [7:0]  s;
        logic        stl;
        logic        ab;
        logic [14:0] exp;   // {busy, done, w_ps, w_load_en, input_en, out_en}
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [2:0] IDL = 3'b001;  // busy done w_ps
    localparam logic [2:0] LDW = 3'b101;
    localparam logic [2:0] STR = 3'b100;
    localparam logic [2:0] DNE = 3'b011;

    task automatic add(input logic st, input logic [2:0] k, input logic [2:0] a,
                       input logic [7:0] s, input logic stl, input logic ab,
                       input logic [2:0] bdw, input logic [3:0] wl,
                       input logic [3:0] ie, input logic [3:0] oe);
        vec_t v;
        v.st = st; v.k = k; v.a = a; v.s = s; v.stl = stl; v.ab = ab;
        v.exp = {bdw, wl, ie, oe};
        vq.push_back(v);
    endtask

    // Non-start cycle with junk config on the inputs (must be ignored).
    task automatic addn(input logic stl, input logic ab, input logic [2:0] bdw,
                        input logic [3:0] wl, input logic [3:0] ie, input logic [3:0] oe);
        add(1'b0, 3'd3, 3'd4, 8'd7, stl, ab, bdw, wl, ie, oe);
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    initial begin
        int done_cyc;

        // Scenario 1: K=2 A=3 S=4, start at cycle 0; start in DONE ignored.
        add (1, 3'd2, 3'd3, 8'd4, 0, 0, IDL, 4'b0000, 4'b0000, 4'b0000); // 0
        addn(0, 0, LDW, 4'b0001, 4'b0000, 4'b0000);                      // 1
        addn(0, 0, LDW, 4'b0010, 4'b0000, 4'b0000);                      // 2
        addn(0, 0, STR, 4'b0000, 4'b0001, 4'b0000);                      // 3
        addn(0, 0, STR, 4'b0000, 4'b0011, 4'b0000);                      // 4
        addn(0, 0, STR, 4'b0000, 4'b0011, 4'b0001);                      // 5
        addn(0, 0, STR, 4'b0000, 4'b0011, 4'b0011);                      // 6
        addn(0, 0, STR, 4'b0000, 4'b0010, 4'b0111);                      // 7
        addn(0, 0, STR, 4'b0000, 4'b0000, 4'b0111);                      // 8
        addn(0, 0, STR, 4'b0000, 4'b0000, 4'b0110);                      // 9
        addn(0, 0, STR, 4'b0000, 4'b0000, 4'b0100);                      // 10
        add (1, 3'd2, 3'd3, 8'd4, 0, 0, DNE, 4'b0000, 4'b0000, 4'b0000); // 11
        // Scenario 2: same job, stall during relative cycles 5-6.
        add (1, 3'd2, 3'd3, 8'd4, 0, 0, IDL, 4'b0000, 4'b0000, 4'b0000); // 0
        addn(0, 0, LDW, 4'b0001, 4'b0000, 4'b0000);                      // 1
        addn(0, 0, LDW, 4'b0010, 4'b0000, 4'b0000);                      // 2
        addn(0, 0, STR, 4'b0000, 4'b0001, 4'b0000);                      // 3
        addn(0, 0, STR, 4'b0000, 4'b0011, 4'b0000);                      // 4
        addn(1, 0, STR, 4'b0000, 4'b0000, 4'b0000);                      // 5
        addn(1, 0, STR, 4'b0000, 4'b0000, 4'b0000);                      // 6
        addn(0, 0, STR, 4'b0000, 4'b0011, 4'b0001);                      // 7
        addn(0, 0, STR, 4'b0000, 4'b0011, 4'b0011);                      // 8
        addn(0, 0, STR, 4'b0000, 4'b0010, 4'b0111);                      // 9
        addn(0, 0, STR, 4'b0000, 4'b0000, 4'b0111);                      // 10
        addn(0, 0, STR, 4'b0000, 4'b0000, 4'b0110);                      // 11
        addn(0, 0, STR, 4'b0000, 4'b0000, 4'b0100);                      // 12
        addn(0, 0, DNE, 4'b0000, 4'b0000, 4'b0000);                      // 13
        // Scenario 3: same job, abort (with stall) at cycle 6, then K=A=S=1.
        add (1, 3'd2, 3'd3, 8'd4, 0, 0, IDL, 4'b0000, 4'b0000, 4'b0000); // 0
        addn(0, 0, LDW, 4'b0001, 4'b0000, 4'b0000);                      // 1
        addn(0, 0, LDW, 4'b0010, 4'b0000, 4'b0000);                      // 2
        addn(0, 0, STR, 4'b0000, 4'b0001, 4'b0000);                      // 3
        addn(0, 0, STR, 4'b0000, 4'b0011, 4'b0000);                      // 4
        addn(0, 0, STR, 4'b0000, 4'b0011, 4'b0001);                      // 5
        addn(1, 1, STR, 4'b0000, 4'b0000, 4'b0000);                      // 6
        add (1, 3'd1, 3'd1, 8'd1, 0, 0, IDL, 4'b0000, 4'b0000, 4'b0000); // 7
        addn(0, 0, LDW, 4'b0001, 4'b0000, 4'b0000);                      // 8
        addn(0, 0, STR, 4'b0000, 4'b0001, 4'b0000);                      // 9
        addn(0, 0, STR, 4'b0000, 4'b0000, 4'b0001);                      // 10
        addn(0, 0, DNE, 4'b0000, 4'b0000, 4'b0000);                      // 11
        // Illegal starts: K=0, A=COLS+1, S=0, K=ROWS+1 (with stall in IDLE).
        add (1, 3'd0, 3'd3, 8'd4, 0, 0, IDL, 4'b0000, 4'b0000, 4'b0000);
        add (1, 3'd2, 3'd5, 8'd4, 0, 0, IDL, 4'b0000, 4'b0000, 4'b0000);
        add (1, 3'd2, 3'd3, 8'd0, 0, 0, IDL, 4'b0000, 4'b0000, 4'b0000);
        add (1, 3'd5, 3'd3, 8'd4, 1, 0, IDL, 4'b0000, 4'b0000, 4'b0000);
        addn(0, 0, IDL, 4'b0000, 4'b0000, 4'b0000);
        addn(0, 0, IDL, 4'b0000, 4'b0000, 4'b0000);

        nrst = 1'b0;
        start = 0; stall = 0; abort = 0; k_rows = 0; act_cols = 0; stream_len = 0;
        start_b = 0; stall_b = 0; abort_b = 0; k_b = 0; a_b = 0; s_b = 0;
        #12;
        chk("reset_small", {busy, done, w_ps, w_load_en, input_en, out_en}, {IDL, 12'h000});
        chk("reset_big_ctl", {busy_b, done_b, w_ps_b}, IDL);
        @(negedge clk);
        nrst = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            start = vq[i].st; k_rows = vq[i].k; act_cols = vq[i].a;
            stream_len = vq[i].s; stall = vq[i].stl; abort = vq[i].ab;
            #1;
            chk($sformatf("vec%0d", i), {busy, done, w_ps, w_load_en, input_en, out_en}, vq[i].exp);
        end
        @(negedge clk);
        start = 0; stall = 0; abort = 0;

        // Full-size job K=32 A=32 S=255: last output cycle at t=317, done at 351.
        start_b = 1; k_b = 6'd32; a_b = 6'd32; s_b = 8'd255;
        done_cyc = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start_b = 0;
            #1;
            if (c == 350) begin
                chk("big_oe_t317", out_en_b, 32'h8000_0000);
                chk("big_ie_t317", input_en_b, 32'h0);
            end
            if (done_b && done_cyc < 0) done_cyc = c;
            if (done_cyc >= 0 && c > done_cyc + 1) break;
        end
        chk("big_done_cycle", done_cyc, 351);
        chk("big_idle_after", {busy_b, done_b, w_ps_b}, IDL);

        // Second full-size job, async reset asserted mid-STREAM.
        @(negedge clk);
        start_b = 1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start_b = 0;
        end
        #1;
        chk("big_busy_mid", busy_b, 1);
        chk("big_ie_mid", input_en_b, 32'hFFFF_FFFF);
        nrst = 1'b0;
        #1;
        chk("big_async_rst_ctl", {busy_b, done_b, w_ps_b}, IDL);
        chk("big_async_rst_ie", input_en_b, 32'h0);
        chk("big_async_rst_oe", out_en_b, 32'h0);
        chk("big_async_rst_wl", w_load_en_b, 32'h0);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        #1;
        chk("big_idle_post_rst", {busy_b, done_b, w_ps_b, input_en_b}, {IDL, 32'h0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_conv_seq.md
# systolic_conv_seq

Parametrised sequencer for the weight-stationary systolic array. On a `start` it loads a programmable number of weight rows one row per cycle. It then streams skewed input vectors into the active rows and raises skewed output-collect enables on the active columns. It supports a stall and an abort, and signals completion with a one-cycle `done`. It sits between the layer scheduler and the PE array, driving `w_ps`, the per-row weight and input enables, and the per-column output enables.

## Interface
- `ROWS`, 32, number of PE rows in the array.
- `COLS`, 32, number of PE columns in the array.
- `CNT_W`, 8, width of `stream_len`.
- `RW` = $clog2(ROWS+1), `CW` = $clog2(COLS+1), `TW` = CNT_W+$clog2(ROWS+COLS)+1 (derived, not overridable).

Ports:
- `clk`  in  1  single clock, rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request; sampled in IDLE only.
- `k_rows`  in  RW  active weight rows; legal range 1..ROWS.
- `act_cols`  in  CW  active output columns; legal range 1..COLS.
- `stream_len`  in  CNT_W  input vectors per row; legal range ≥1.
- `stall`  in  1  freezes progress while high.
- `abort`  in  1  synchronous return to IDLE.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle completion pulse.
- `w_ps`  out  1  1 = weight-load mode, 0 = partial-sum mode.
- `w_load_en`  out  ROWS  one-hot weight-row write strobe.
- `input_en`  out  ROWS  per-row input-valid enable.
- `out_en`  out  COLS  per-column output-collect enable.

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE:
  - `w_ps`=1; `busy`, `done` and all enables are 0.
  - `start`=1 with all three config fields legal: latch them into K, A, S and go to LOAD_W.
  - `start`=1 with any field zero or out of range: ignored, stay in IDLE, no `done`.
- LOAD_W:
  - Row counter r runs 0..K-1; `w_load_en` = one-hot bit r; `w_ps`=1; `busy`=1.
  - After r==K-1, clear timer t to 0 and go to STREAM.
- STREAM and DRAIN share timer t (TW bits); `w_ps`=0; `busy`=1.
  - `input_en[i]` = 1 iff i<K and i ≤ t ≤ i+S-1.
  - `out_en[c]` = 1 iff c<A and K+c ≤ t ≤ K+c+S-1.
  - Row and column bits at or beyond K/A stay 0.
  - STREAM→DRAIN after t == K+S-2, the last input cycle.
  - DRAIN→DONE after t == K+A+S-2, the last output cycle.
- DONE: `done`=1, `busy`=0, `w_ps`=1, enables 0; next state is IDLE unconditionally. `start` is ignored in DONE.
- `stall`=1 in LOAD_W, STREAM or DRAIN:
  - r, t and state hold.
  - `w_load_en`, `input_en` and `out_en` are forced to 0 combinationally.
  - `busy` and `w_ps` are unchanged.
  - `stall` has no effect in IDLE or DONE.
- `abort`=1 in any non-IDLE state: next state IDLE, counters cleared, no `done`. `abort` takes priority over `stall`.
- Config inputs are don't-care after latching; changes mid-job have no effect.
- All counters are unsigned. Compare bounds are computed at full TW width, with no wrap, for maximum K, A and S.

## Timing
- Reset (async, `nrst`=0): state IDLE, r=t=0, `w_ps`=1, `busy`=0, `done`=0, all enable vectors 0.
- Outputs are decoded from registered state and counters. Only the `stall` gating is combinational from inputs.
- `start` sampled at edge E:
  - LOAD_W occupies cycles E+1..E+K.
  - STREAM begins at E+K+1 with t=0.
  - `done` is high in cycle E+2K+A+S, plus one cycle per stalled cycle.
- Back-to-back jobs: the earliest accepted `start` is in the IDLE cycle following DONE, so there is a one-cycle gap minimum.
- Stall between any two cycles shifts all subsequent enables by exactly the stall length. The enable pattern is otherwise identical.

## Test plan
- ROWS=COLS=4; K=2, A=3, S=4; `start` at cycle 0. Required response:
  - `w_load_en` = 0001 at cycle 1 and 0010 at cycle 2.
  - `input_en[0]` high cycles 3–6; `input_en[1]` high cycles 4–7.
  - `out_en[0]` high 5–8, `out_en[1]` high 6–9, `out_en[2]` high 7–10.
  - `done` high at cycle 11 only; `busy` high cycles 1–10.
- K=A=S=1 minimal job: `w_load_en[0]` at cycle 1, `input_en[0]` at cycle 2, `out_en[0]` at cycle 3, `done` at cycle 4.
- Same job as the first scenario with `stall` high during cycles 5–6: enables are 0 during the stall, every later event shifts by +2, and `done` moves to cycle 13.
- `abort` at cycle 6 of the first scenario: IDLE at cycle 7, all enables 0, `w_ps`=1, no `done`. A new `start` at cycle 7 is accepted.
- `start` with K=0, or A=COLS+1, or S=0: stays in IDLE, `busy` never rises, no enables, no `done`.
- Full-size defaults, K=32, A=32, S=255: t reaches 317 without wrap, `done` at cycle 64+32+255 = 351. Assert `nrst` low mid-STREAM: all outputs return to their reset values immediately, without waiting for a clock edge.
